// File: rtl/wb_stage_if.sv
// GPR write-port bundle between the writeback stage (master) and the GPR file (slave).
// A write commits on any cycle where rd_wr is high; rd_addr/rd_data are stable otherwise.
interface rbus #(
  parameter int RSZ     = 32,
  parameter int GPR_ASZ = 5
);
  logic               rd_wr;
  logic [GPR_ASZ-1:0] rd_addr;
  logic [RSZ-1:0]     rd_data;

  modport master (output rd_wr, output rd_addr, output rd_data);
  modport slave  (input  rd_wr, input  rd_addr, input  rd_data);
endinterface

// File: rtl/wb_stage.sv
// Writeback: retires MEM instructions into the GPR file. Rd_wr follows accept (non-load) or dc_ld_valid (load) by one cycle.
// mem_ready drops only while a load waits for D$ data; throughput is one retire per cycle otherwise.
module wb_stage #(
  parameter int RSZ     = 32,
  parameter int GPR_ASZ = 5,
  parameter int CNT_SZ  = 64
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic               mem_rd_wr,
  input  logic [GPR_ASZ-1:0] mem_rd_addr,
  input  logic [RSZ-1:0]     mem_alu_data,
  input  logic               mem_is_load,
  input  logic [1:0]         mem_ld_size,
  input  logic               mem_ld_unsigned,
  input  logic [1:0]         mem_ld_off,
  input  logic               dc_ld_valid,
  input  logic [RSZ-1:0]     dc_ld_data,
  input  logic               dc_ld_err,
  rbus.master                gpr_bus,
  output logic               ld_pending,
  output logic [GPR_ASZ-1:0] ld_pending_addr,
  output logic               ld_fault,
  output logic [CNT_SZ-1:0]  instret
);

  typedef enum logic [1:0] {EMPTY, WAIT_LD, WRITE} state_t;

  state_t             state_q, state_d;
  logic               rd_wr_q, rd_wr_d;
  logic [GPR_ASZ-1:0] rd_addr_q, rd_addr_d;
  logic [RSZ-1:0]     rd_data_q, rd_data_d;
  logic               pend_wr_q, pend_wr_d;
  logic [GPR_ASZ-1:0] pend_rd_q, pend_rd_d;
  logic [1:0]         pend_size_q, pend_size_d;
  logic               pend_uns_q, pend_uns_d;
  logic [1:0]         pend_off_q, pend_off_d;
  logic               ld_fault_q, ld_fault_d;
  logic [CNT_SZ-1:0]  instret_q, instret_d;

  logic               retire;
  logic               ret_wr;
  logic [GPR_ASZ-1:0] ret_addr;
  logic [RSZ-1:0]     ret_data;

  function automatic logic [RSZ-1:0] ld_format(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [RSZ-1:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    logic [RSZ-1:0] r;
    case (off)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = off[1] ? data[31:16] : data[15:0];
    case (size)
      2'd0:    r = {{(RSZ-8){b[7] & ~uns}}, b};
      2'd1:    r = {{(RSZ-16){h[15] & ~uns}}, h};
      default: r = data;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    rd_wr_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    pend_wr_d   = pend_wr_q;
    pend_rd_d   = pend_rd_q;
    pend_size_d = pend_size_q;
    pend_uns_d  = pend_uns_q;
    pend_off_d  = pend_off_q;
    ld_fault_d  = 1'b0;
    instret_d   = instret_q;
    retire      = 1'b0;
    ret_wr      = 1'b0;
    ret_addr    = '0;
    ret_data    = '0;

    case (state_q)
      WAIT_LD: begin
        if (dc_ld_err) begin
          state_d    = EMPTY;
          ld_fault_d = 1'b1;
        end else if (dc_ld_valid) begin
          retire   = 1'b1;
          ret_wr   = pend_wr_q;
          ret_addr = pend_rd_q;
          ret_data = ld_format(pend_size_q, pend_uns_q, pend_off_q, dc_ld_data);
        end
      end
      default: begin
        // EMPTY and WRITE share the accept rules, giving back-to-back retires.
        state_d = EMPTY;
        if (mem_valid) begin
          if (!mem_is_load) begin
            retire   = 1'b1;
            ret_wr   = mem_rd_wr;
            ret_addr = mem_rd_addr;
            ret_data = mem_alu_data;
          end else if (dc_ld_err) begin
            ld_fault_d = 1'b1;
          end else if (dc_ld_valid) begin
            retire   = 1'b1;
            ret_wr   = mem_rd_wr;
            ret_addr = mem_rd_addr;
            ret_data = ld_format(mem_ld_size, mem_ld_unsigned, mem_ld_off, dc_ld_data);
          end else begin
            state_d     = WAIT_LD;
            pend_wr_d   = mem_rd_wr;
            pend_rd_d   = mem_rd_addr;
            pend_size_d = mem_ld_size;
            pend_uns_d  = mem_ld_unsigned;
            pend_off_d  = mem_ld_off;
          end
        end
      end
    endcase

    if (retire) begin
      state_d   = WRITE;
      instret_d = instret_q + 1'b1;
      // Address/data only move on a real write so the bus holds its last write otherwise.
      if (ret_wr && (ret_addr != '0)) begin
        rd_wr_d   = 1'b1;
        rd_addr_d = ret_addr;
        rd_data_d = ret_data;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= EMPTY;
      rd_wr_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      pend_wr_q   <= 1'b0;
      pend_rd_q   <= '0;
      pend_size_q <= '0;
      pend_uns_q  <= 1'b0;
      pend_off_q  <= '0;
      ld_fault_q  <= 1'b0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_wr_q     <= rd_wr_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      pend_wr_q   <= pend_wr_d;
      pend_rd_q   <= pend_rd_d;
      pend_size_q <= pend_size_d;
      pend_uns_q  <= pend_uns_d;
      pend_off_q  <= pend_off_d;
      ld_fault_q  <= ld_fault_d;
      instret_q   <= instret_d;
    end
  end

  assign mem_ready       = (state_q != WAIT_LD);
  assign ld_pending      = (state_q == WAIT_LD);
  assign ld_pending_addr = (state_q == WAIT_LD) ? pend_rd_q : '0;
  assign ld_fault        = ld_fault_q;
  assign instret         = instret_q;
  assign gpr_bus.rd_wr   = rd_wr_q;
  assign gpr_bus.rd_addr = rd_addr_q;
  assign gpr_bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: retire paths, load formatting, x0 suppression, faults and reset mid-load.
module tb_wb_stage;
  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_rd_wr;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_alu_data;
  logic        mem_is_load;
  logic [1:0]  mem_ld_size;
  logic        mem_ld_unsigned;
  logic [1:0]  mem_ld_off;
  logic        dc_ld_valid;
  logic [31:0] dc_ld_data;
  logic        dc_ld_err;
  logic        ld_pending;
  logic [4:0]  ld_pending_addr;
  logic        ld_fault;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  rbus #(.RSZ(32), .GPR_ASZ(5)) gpr_bus ();

  wb_stage #(.RSZ(32), .GPR_ASZ(5), .CNT_SZ(64)) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_rd_wr       (mem_rd_wr),
    .mem_rd_addr     (mem_rd_addr),
    .mem_alu_data    (mem_alu_data),
    .mem_is_load     (mem_is_load),
    .mem_ld_size     (mem_ld_size),
    .mem_ld_unsigned (mem_ld_unsigned),
    .mem_ld_off      (mem_ld_off),
    .dc_ld_valid     (dc_ld_valid),
    .dc_ld_data      (dc_ld_data),
    .dc_ld_err       (dc_ld_err),
    .gpr_bus         (gpr_bus.master),
    .ld_pending      (ld_pending),
    .ld_pending_addr (ld_pending_addr),
    .ld_fault        (ld_fault),
    .instret         (instret)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1ns after the edge, where registered outputs are settled.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0; mem_rd_wr = 1'b0; mem_rd_addr = '0; mem_alu_data = '0;
    mem_is_load = 1'b0; mem_ld_size = '0; mem_ld_unsigned = 1'b0; mem_ld_off = '0;
    dc_ld_valid = 1'b0; dc_ld_data = '0; dc_ld_err = 1'b0;
  endtask

  task automatic op(input logic wr, input logic [4:0] rd, input logic [31:0] d);
    mem_valid = 1'b1; mem_is_load = 1'b0; mem_rd_wr = wr; mem_rd_addr = rd; mem_alu_data = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [1:0] sz, input logic uns, input logic [1:0] off);
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_rd_wr = 1'b1; mem_rd_addr = rd;
    mem_ld_size = sz; mem_ld_unsigned = uns; mem_ld_off = off;
  endtask

  initial begin
    idle();
    reset_in = 1'b1;
    step();
    step();
    chk("rst_rd_wr", 64'(gpr_bus.rd_wr), 64'd0);
    chk("rst_rd_addr", 64'(gpr_bus.rd_addr), 64'd0);
    chk("rst_rd_data", 64'(gpr_bus.rd_data), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_pending", 64'(ld_pending), 64'd0);
    chk("rst_fault", 64'(ld_fault), 64'd0);
    chk("rst_ready", 64'(mem_ready), 64'd1);
    reset_in = 1'b0;

    // 1: back-to-back ALU retires
    op(1'b1, 5'd5, 32'h11);
    step();
    chk("t1_wr0", 64'(gpr_bus.rd_wr), 64'd1);
    chk("t1_addr0", 64'(gpr_bus.rd_addr), 64'd5);
    chk("t1_data0", 64'(gpr_bus.rd_data), 64'h11);
    op(1'b1, 5'd6, 32'h22);
    step();
    chk("t1_wr1", 64'(gpr_bus.rd_wr), 64'd1);
    chk("t1_addr1", 64'(gpr_bus.rd_addr), 64'd6);
    chk("t1_data1", 64'(gpr_bus.rd_data), 64'h22);
    chk("t1_instret", instret, 64'd2);
    idle();
    step();
    chk("t1_idle_wr", 64'(gpr_bus.rd_wr), 64'd0);
    chk("t1_hold_data", 64'(gpr_bus.rd_data), 64'h22);

    // 2: LB x7 off=3, data three cycles late
    ld(5'd7, 2'd0, 1'b0, 2'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      idle();
      chk($sformatf("t2_pend%0d", i), 64'(ld_pending), 64'd1);
      chk($sformatf("t2_paddr%0d", i), 64'(ld_pending_addr), 64'd7);
      chk($sformatf("t2_ready%0d", i), 64'(mem_ready), 64'd0);
      chk($sformatf("t2_wr%0d", i), 64'(gpr_bus.rd_wr), 64'd0);
    end
    dc_ld_valid = 1'b1; dc_ld_data = 32'h8012_3456;
    step();
    idle();
    chk("t2_wr", 64'(gpr_bus.rd_wr), 64'd1);
    chk("t2_addr", 64'(gpr_bus.rd_addr), 64'd7);
    chk("t2_data", 64'(gpr_bus.rd_data), 64'hFFFF_FF80);
    chk("t2_pend_clr", 64'(ld_pending), 64'd0);
    chk("t2_instret", instret, 64'd3);

    // 3: same-cycle load data, several formats back to back
    ld(5'd8, 2'd1, 1'b1, 2'd2); dc_ld_valid = 1'b1; dc_ld_data = 32'hBEEF_1234;
    step();
    chk("t3_lhu", 64'(gpr_bus.rd_data), 64'h0000_BEEF);
    chk("t3_lhu_addr", 64'(gpr_bus.rd_addr), 64'd8);
    ld(5'd9, 2'd1, 1'b0, 2'd1); dc_ld_data = 32'h1234_8001;
    step();
    chk("t3_lh", 64'(gpr_bus.rd_data), 64'hFFFF_8001);
    ld(5'd10, 2'd0, 1'b1, 2'd1); dc_ld_data = 32'h0000_F200;
    step();
    chk("t3_lbu", 64'(gpr_bus.rd_data), 64'h0000_00F2);
    ld(5'd11, 2'd3, 1'b0, 2'd1); dc_ld_data = 32'hCAFE_BABE;
    step();
    chk("t3_sz3_word", 64'(gpr_bus.rd_data), 64'hCAFE_BABE);
    chk("t3_wr", 64'(gpr_bus.rd_wr), 64'd1);
    chk("t3_instret", instret, 64'd7);

    // 4: x0 write and a store retire without writing
    idle();
    op(1'b1, 5'd0, 32'hDEAD);
    step();
    chk("t4_x0_wr", 64'(gpr_bus.rd_wr), 64'd0);
    chk("t4_x0_addr_hold", 64'(gpr_bus.rd_addr), 64'd11);
    op(1'b0, 5'd3, 32'h55);
    step();
    chk("t4_st_wr", 64'(gpr_bus.rd_wr), 64'd0);
    chk("t4_st_data_hold", 64'(gpr_bus.rd_data), 64'hCAFE_BABE);
    chk("t4_instret", instret, 64'd9);
    idle();
    step();

    // 5: load fault in WAIT_LD, then stray D$ strobes while EMPTY
    ld(5'd12, 2'd2, 1'b0, 2'd0);
    step();
    idle();
    chk("t5_pend", 64'(ld_pending), 64'd1);
    dc_ld_err = 1'b1;
    step();
    idle();
    chk("t5_fault", 64'(ld_fault), 64'd1);
    chk("t5_wr", 64'(gpr_bus.rd_wr), 64'd0);
    chk("t5_ready", 64'(mem_ready), 64'd1);
    chk("t5_instret", instret, 64'd9);
    dc_ld_valid = 1'b1; dc_ld_data = 32'h1;
    step();
    idle();
    chk("t5_fault_pulse", 64'(ld_fault), 64'd0);
    chk("t5_stray_wr", 64'(gpr_bus.rd_wr), 64'd0);
    chk("t5_stray_instret", instret, 64'd9);

    // err and valid together in WAIT_LD: the fault wins
    ld(5'd13, 2'd2, 1'b0, 2'd0);
    step();
    idle();
    dc_ld_err = 1'b1; dc_ld_valid = 1'b1; dc_ld_data = 32'h77;
    step();
    idle();
    chk("t5b_fault", 64'(ld_fault), 64'd1);
    chk("t5b_wr", 64'(gpr_bus.rd_wr), 64'd0);
    chk("t5b_instret", instret, 64'd9);

    // load with err on the accept cycle
    ld(5'd14, 2'd2, 1'b0, 2'd0); dc_ld_err = 1'b1;
    step();
    idle();
    chk("t5c_fault", 64'(ld_fault), 64'd1);
    chk("t5c_pend", 64'(ld_pending), 64'd0);

    // 6: reset while waiting on a load
    ld(5'd15, 2'd2, 1'b0, 2'd0);
    step();
    idle();
    chk("t6_pend", 64'(ld_pending), 64'd1);
    reset_in = 1'b1;
    step();
    chk("t6_rst_pend", 64'(ld_pending), 64'd0);
    chk("t6_rst_paddr", 64'(ld_pending_addr), 64'd0);
    chk("t6_rst_instret", instret, 64'd0);
    chk("t6_rst_addr", 64'(gpr_bus.rd_addr), 64'd0);
    reset_in = 1'b0;
    dc_ld_valid = 1'b1; dc_ld_data = 32'hFFFF_FFFF;
    step();
    idle();
    chk("t6_wr", 64'(gpr_bus.rd_wr), 64'd0);
    chk("t6_ready", 64'(mem_ready), 64'd1);
    chk("t6_instret", instret, 64'd0);
    chk("t6_data", 64'(gpr_bus.rd_data), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
